spm_port_adapter: RTL and testbench
===================================

SPM_PORT_ADAPTER -- requirements
Module: spm_port_adapter

Interface
REQ-001 SHALL have parameter spmBaseAddress, default 32'hC0000000, byte base of the scratchpad window.
REQ-002 SHALL have parameter spmSizeInBytes, default 8192, window size (power of two).
REQ-003 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpuRequest  in  1  access request, sampled only while cpuBusy=0.
REQ-006 SHALL have port cpuAddress  in  32  byte address.
REQ-007 SHALL have port cpuWe  in  1  1=store, 0=load.
REQ-008 SHALL have port cpuSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port cpuSignExtend  in  1  sign-extend loads of byte/half.
REQ-010 SHALL have port cpuWriteData  in  32  store data, right-aligned.
REQ-011 SHALL have port cpuBusy  out  1  high whenever FSM not IDLE.
REQ-012 SHALL have port cpuReady  out  1  one-cycle completion pulse.
REQ-013 SHALL have port cpuError  out  1  qualifies cpuReady; misaligned/out-of-window/illegal size.
REQ-014 SHALL have port cpuReadData  out  32  formatted load data, valid with cpuReady.
REQ-015 SHALL have ports spmAddress out 18 (word address), spmByteEnables out 4, spmCs out 1, spmWe out 1, dataToSpm out 32, dataFromSpm in 32 (registered SPM read port).

Function
REQ-016 Hit SHALL be cpuAddress[31:log2(spmSizeInBytes)] == spmBaseAddress[31:log2(spmSizeInBytes)].
REQ-017 Aligned SHALL mean half: addr[0]=0; word: addr[1:0]=0; byte: always.
REQ-018 Acceptance: IDLE and cpuRequest=1; accepted request SHALL drive spmCs/spmWe/spmAddress/spmByteEnables/dataToSpm combinationally in that cycle (N) only if hit, aligned, size legal.
REQ-019 spmAddress SHALL be zero-extended cpuAddress[log2(spmSizeInBytes)-1:2]; spmCs=0 and spmByteEnables=0 in all other cycles.
REQ-020 Byte enables little-endian: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads SHALL assert the same enables.
REQ-021 dataToSpm SHALL replicate: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
REQ-022 FSM states IDLE, RD1, RD2, RESP. Store/error: IDLE->RESP; load: IDLE->RD1->RD2->RESP; RESP->IDLE unconditionally.
REQ-023 In RD2 (cycle N+2) dataFromSpm SHALL be captured, lane-shifted right by 8*addr[1:0], zero- or sign-extended per cpuSize/cpuSignExtend; address/size/sign fields latched at acceptance.
REQ-024 cpuReady SHALL be high exactly in RESP: cycle N+1 for stores and errors, N+3 for loads.
REQ-025 Error requests SHALL not assert spmCs; cpuError=1 with cpuReady; cpuReadData=0 for errors and stores.
REQ-026 Requests while cpuBusy=1 SHALL be ignored (no spm activity); cpuRequest held across RESP SHALL be accepted only after return to IDLE (back-to-back rate: one store per 2 cycles).
REQ-027 cpuReadData SHALL hold its value until next load completion.

Reset
REQ-028 reset SHALL force IDLE, cpuBusy/cpuReady/cpuError=0, cpuReadData=0, latched fields 0, asynchronously.
REQ-029 reset during RD1/RD2/RESP SHALL abort: no cpuReady pulse after reset release.

Structure
REQ-030 Shared package spm_port_pkg SHALL hold size encodings (SIZE_BYTE/HALF/WORD), FSM state encodings, and 32'hC0000000 default base.
REQ-031 Sub-module spm_load_formatter SHALL implement REQ-023 lane extraction and extension, purely combinational.

Verification
REQ-032 Store word 32'hDEADBEEF to 32'hC0000010 -> cycle N spmCs=1, spmWe=1, spmAddress=18'h4, spmByteEnables=4'hF; cpuReady=1 at N+1, cpuError=0.
REQ-033 Load byte signed from 32'hC0000013 with word=32'h80FF7F01 -> spmByteEnables=4'b1000, cpuReadData=32'hFFFFFF80 at N+3.
REQ-034 Load half unsigned 32'hC0000012 same word -> 32'h000080FF; half at 32'hC0000011 -> cpuError=1 at N+1, spmCs never high.
REQ-035 Load from 32'hC0002000 (outside 8 KiB) -> error at N+1, no spm access; store byte 8'hA5 at 32'hC0001FFF -> spmAddress=18'h7FF, enables 4'b1000, dataToSpm=32'hA5A5A5A5.
REQ-036 Assert reset in RD2 of a load -> cpuBusy=0 immediately, no cpuReady afterward; next request served normally.

Source files
------------

// File: rtl/spm_port_pkg.sv
// Shared encodings for the scratchpad port adapter: access sizes, FSM states
// and the default scratchpad window base.
package spm_port_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [31:0] SPM_DEFAULT_BASE = 32'hC0000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RESP = 2'd3
  } spmState_e;

endpackage

// File: rtl/spm_load_formatter.sv
// Moves the addressed byte/half lane of a 32-bit SPM word down to bit 0 and
// zero- or sign-extends it to 32 bits.
module spm_load_formatter
  import spm_port_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byteOffset,
  input  logic [1:0]  size,
  input  logic        signExtend,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {byteOffset, 3'b000};
    result  = shifted;
    case (size)
      SIZE_BYTE: result = {{24{signExtend & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result = {{16{signExtend & shifted[15]}}, shifted[15:0]};
      default:   result = shifted;
    endcase
  end

endmodule

// File: rtl/spm_port_adapter.sv
// CPU load/store port to a single-port scratchpad with a registered read port.
// Checks window hit, alignment and size, then issues one SPM access per request.
module spm_port_adapter
  import spm_port_pkg::*;
#(
  parameter logic [31:0] spmBaseAddress = SPM_DEFAULT_BASE,
  parameter int          spmSizeInBytes = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuRequest,
  input  logic [31:0] cpuAddress,
  input  logic        cpuWe,
  input  logic [1:0]  cpuSize,
  input  logic        cpuSignExtend,
  input  logic [31:0] cpuWriteData,
  output logic        cpuBusy,
  output logic        cpuReady,
  output logic        cpuError,
  output logic [31:0] cpuReadData,
  output logic [17:0] spmAddress,
  output logic [3:0]  spmByteEnables,
  output logic        spmCs,
  output logic        spmWe,
  output logic [31:0] dataToSpm,
  input  logic [31:0] dataFromSpm
);

  localparam logic [31:0] OFFSET_MASK = 32'(spmSizeInBytes - 1);

  spmState_e   stateReg, stateNext;
  logic [1:0]  byteOffsetReg;
  logic [1:0]  sizeReg;
  logic        signReg;
  logic        errorReg;
  logic        isLoadReg;
  logic [31:0] readDataReg;
  logic [31:0] formattedData;

  logic [31:0] windowOffset;
  logic        hit, aligned, sizeLegal, accept, accessOk;
  logic [3:0]  rawEnables;
  logic [31:0] rawWriteData;

  always_comb begin
    windowOffset = cpuAddress & OFFSET_MASK;
    hit          = (cpuAddress & ~OFFSET_MASK) == (spmBaseAddress & ~OFFSET_MASK);
    sizeLegal    = cpuSize != SIZE_ILLEGAL;
    aligned      = 1'b1;
    rawEnables   = 4'b1111;
    rawWriteData = cpuWriteData;
    case (cpuSize)
      SIZE_BYTE: begin
        rawEnables   = 4'b0001 << cpuAddress[1:0];
        rawWriteData = {4{cpuWriteData[7:0]}};
      end
      SIZE_HALF: begin
        aligned      = ~cpuAddress[0];
        rawEnables   = 4'b0011 << cpuAddress[1:0];
        rawWriteData = {2{cpuWriteData[15:0]}};
      end
      default: aligned = cpuAddress[1:0] == 2'b00;
    endcase
    accept   = (stateReg == IDLE) && cpuRequest;
    accessOk = accept && hit && aligned && sizeLegal;
  end

  // The SPM side is only ever driven in the acceptance cycle of a good request.
  assign spmCs          = accessOk;
  assign spmWe          = accessOk & cpuWe;
  assign spmAddress     = accessOk ? 18'(windowOffset >> 2) : 18'd0;
  assign spmByteEnables = accessOk ? rawEnables : 4'b0000;
  assign dataToSpm      = accessOk ? rawWriteData : 32'd0;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (accept) stateNext = (!accessOk || cpuWe) ? RESP : RD1;
      RD1:  stateNext = RD2;
      RD2:  stateNext = RESP;
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg      <= IDLE;
      byteOffsetReg <= 2'b00;
      sizeReg       <= 2'b00;
      signReg       <= 1'b0;
      errorReg      <= 1'b0;
      isLoadReg     <= 1'b0;
      readDataReg   <= 32'd0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        byteOffsetReg <= cpuAddress[1:0];
        sizeReg       <= cpuSize;
        signReg       <= cpuSignExtend;
        errorReg      <= ~accessOk;
        isLoadReg     <= accessOk & ~cpuWe;
      end
      if (stateReg == RD2) readDataReg <= formattedData;
    end
  end

  spm_load_formatter uFormatter (
    .word       (dataFromSpm),
    .byteOffset (byteOffsetReg),
    .size       (sizeReg),
    .signExtend (signReg),
    .result     (formattedData)
  );

  assign cpuBusy  = stateReg != IDLE;
  assign cpuReady = stateReg == RESP;
  assign cpuError = (stateReg == RESP) && errorReg;
  // Stores and errors report zero, but the last load result stays visible otherwise.
  assign cpuReadData = ((stateReg == RESP) && !isLoadReg) ? 32'd0 : readDataReg;

endmodule

// File: tb/tb_spm_port_adapter.sv
// Directed bench for spm_port_adapter: issues requests against a small SPM
// model and checks responses through an expected-response queue.
module tb_spm_port_adapter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpuRequest = 1'b0;
  logic [31:0] cpuAddress = 32'd0;
  logic        cpuWe = 1'b0;
  logic [1:0]  cpuSize = 2'b00;
  logic        cpuSignExtend = 1'b0;
  logic [31:0] cpuWriteData = 32'd0;
  logic        cpuBusy, cpuReady, cpuError;
  logic [31:0] cpuReadData;
  logic [17:0] spmAddress;
  logic [3:0]  spmByteEnables;
  logic        spmCs, spmWe;
  logic [31:0] dataToSpm;
  logic [31:0] dataFromSpm = 32'd0;

  int checks = 0;
  int failures = 0;
  int csCount = 0;
  int expCsCount = 0;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] data;
  } resp_t;
  resp_t expQ[$];

  logic [31:0] mem [0:262143];

  spm_port_adapter dut (
    .clock          (clock),
    .reset          (reset),
    .cpuRequest     (cpuRequest),
    .cpuAddress     (cpuAddress),
    .cpuWe          (cpuWe),
    .cpuSize        (cpuSize),
    .cpuSignExtend  (cpuSignExtend),
    .cpuWriteData   (cpuWriteData),
    .cpuBusy        (cpuBusy),
    .cpuReady       (cpuReady),
    .cpuError       (cpuError),
    .cpuReadData    (cpuReadData),
    .spmAddress     (spmAddress),
    .spmByteEnables (spmByteEnables),
    .spmCs          (spmCs),
    .spmWe          (spmWe),
    .dataToSpm      (dataToSpm),
    .dataFromSpm    (dataFromSpm)
  );

  always #5 clock = ~clock;

  // Scratchpad model: byte-enabled writes, registered read that holds between reads.
  always @(posedge clock) begin
    if (spmCs) begin
      if (spmWe) begin
        for (int b = 0; b < 4; b++)
          if (spmByteEnables[b]) mem[spmAddress][8*b +: 8] <= dataToSpm[8*b +: 8];
      end else begin
        dataFromSpm <= mem[spmAddress];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every cpuReady pops one expected response.
  always @(negedge clock) begin
    if (spmCs) csCount++;
    if (!reset && cpuReady) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got cpuReady=1 expected no response");
      end else begin
        resp_t r;
        r = expQ.pop_front();
        chk({r.name, "_err"}, 32'(cpuError), 32'(r.err));
        chk({r.name, "_rdata"}, cpuReadData, r.data);
        $display("resp %s err=%0b rdata=%h", r.name, cpuError, cpuReadData);
      end
    end else if (!reset && cpuError) begin
      checks++;
      failures++;
      $display("FAIL error_without_ready: got cpuError=1 expected 0");
    end
  end

  task automatic waitIdle(input string name);
    int n = 0;
    while (cpuBusy && n < 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (cpuBusy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy expected idle", name);
    end
  endtask

  // Called one time unit after a rising edge; returns in the same phase.
  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                       input logic expOk, input logic [17:0] expAddr,
                       input logic [3:0] expBe, input logic [31:0] expWd,
                       input logic [31:0] expRead);
    resp_t r;
    waitIdle({name, "_pre"});
    cpuRequest = 1'b1;
    cpuWe = we;
    cpuSize = size;
    cpuSignExtend = sx;
    cpuAddress = addr;
    cpuWriteData = wd;
    r.name = name;
    r.err = ~expOk;
    r.data = (we || !expOk) ? 32'd0 : expRead;
    expQ.push_back(r);
    @(negedge clock);
    chk({name, "_cs"}, 32'(spmCs), 32'(expOk));
    if (expOk) begin
      expCsCount++;
      chk({name, "_we"}, 32'(spmWe), 32'(we));
      chk({name, "_addr"}, 32'(spmAddress), 32'(expAddr));
      chk({name, "_be"}, 32'(spmByteEnables), 32'(expBe));
      if (we) chk({name, "_wdata"}, dataToSpm, expWd);
    end
    $display("req %s we=%0b size=%0d addr=%h cs=%0b be=%b", name, we, size, addr,
             spmCs, spmByteEnables);
    @(posedge clock);
    #1;
    cpuRequest = 1'b0;
    waitIdle(name);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 32'd0;
    #12;
    chk("reset_busy", 32'(cpuBusy), 32'd0);
    chk("reset_ready", 32'(cpuReady), 32'd0);
    chk("reset_error", 32'(cpuError), 32'd0);
    chk("reset_rdata", cpuReadData, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    //     name            we    size   sx    addr          wdata          ok    spmAddr   be       wd-to-spm      read
    issue("st_w_beef",     1'b1, 2'b10, 1'b0, 32'hC0000010, 32'hDEADBEEF, 1'b1, 18'h4,   4'b1111, 32'hDEADBEEF, 32'h0);
    issue("ld_w_beef",     1'b0, 2'b10, 1'b0, 32'hC0000010, 32'h0,        1'b1, 18'h4,   4'b1111, 32'h0,        32'hDEADBEEF);
    issue("st_w_80ff",     1'b1, 2'b10, 1'b0, 32'hC0000010, 32'h80FF7F01, 1'b1, 18'h4,   4'b1111, 32'h80FF7F01, 32'h0);
    issue("ld_b_s_13",     1'b0, 2'b00, 1'b1, 32'hC0000013, 32'h0,        1'b1, 18'h4,   4'b1000, 32'h0,        32'hFFFFFF80);
    issue("ld_h_u_12",     1'b0, 2'b01, 1'b0, 32'hC0000012, 32'h0,        1'b1, 18'h4,   4'b1100, 32'h0,        32'h000080FF);
    issue("ld_h_s_10",     1'b0, 2'b01, 1'b1, 32'hC0000010, 32'h0,        1'b1, 18'h4,   4'b0011, 32'h0,        32'h00007F01);
    issue("ld_b_s_12",     1'b0, 2'b00, 1'b1, 32'hC0000012, 32'h0,        1'b1, 18'h4,   4'b0100, 32'h0,        32'hFFFFFFFF);
    issue("ld_b_u_11",     1'b0, 2'b00, 1'b0, 32'hC0000011, 32'h0,        1'b1, 18'h4,   4'b0010, 32'h0,        32'h0000007F);
    issue("ld_h_misal",    1'b0, 2'b01, 1'b0, 32'hC0000011, 32'h0,        1'b0, 18'h0,   4'b0000, 32'h0,        32'h0);
    issue("ld_out_win",    1'b0, 2'b10, 1'b0, 32'hC0002000, 32'h0,        1'b0, 18'h0,   4'b0000, 32'h0,        32'h0);
    issue("ld_below_win",  1'b0, 2'b10, 1'b0, 32'hBFFFFFFC, 32'h0,        1'b0, 18'h0,   4'b0000, 32'h0,        32'h0);
    issue("ld_size_ill",   1'b0, 2'b11, 1'b0, 32'hC0000010, 32'h0,        1'b0, 18'h0,   4'b0000, 32'h0,        32'h0);
    issue("st_w_misal",    1'b1, 2'b10, 1'b0, 32'hC0000012, 32'h12345678, 1'b0, 18'h0,   4'b0000, 32'h0,        32'h0);
    issue("st_b_a5",       1'b1, 2'b00, 1'b0, 32'hC0001FFF, 32'h000000A5, 1'b1, 18'h7FF, 4'b1000, 32'hA5A5A5A5, 32'h0);
    issue("ld_b_u_1fff",   1'b0, 2'b00, 1'b0, 32'hC0001FFF, 32'h0,        1'b1, 18'h7FF, 4'b1000, 32'h0,        32'h000000A5);
    issue("st_h_1234",     1'b1, 2'b01, 1'b0, 32'hC0000016, 32'hFFFF1234, 1'b1, 18'h5,   4'b1100, 32'h12341234, 32'h0);
    chk("rdata_hold", cpuReadData, 32'h000000A5);
    issue("ld_w_14",       1'b0, 2'b10, 1'b0, 32'hC0000014, 32'h0,        1'b1, 18'h5,   4'b1111, 32'h0,        32'h12340000);

    // Request held high: stores are accepted only every other cycle.
    begin
      resp_t r;
      cpuRequest = 1'b1;
      cpuWe = 1'b1;
      cpuSize = 2'b10;
      cpuAddress = 32'hC0000020;
      cpuWriteData = 32'h11223344;
      r.name = "b2b_st";
      r.err = 1'b0;
      r.data = 32'd0;
      expQ.push_back(r);
      expQ.push_back(r);
      for (int k = 0; k < 4; k++) begin
        @(negedge clock);
        chk($sformatf("b2b_cs%0d", k), 32'(spmCs), (k % 2 == 0) ? 32'd1 : 32'd0);
        @(posedge clock);
        #1;
      end
      cpuRequest = 1'b0;
      expCsCount += 2;
      waitIdle("b2b");
    end
    issue("ld_w_20",       1'b0, 2'b10, 1'b0, 32'hC0000020, 32'h0,        1'b1, 18'h8,   4'b1111, 32'h0,        32'h11223344);

    // Reset during RD2 aborts the load without a response.
    cpuRequest = 1'b1;
    cpuWe = 1'b0;
    cpuSize = 2'b10;
    cpuAddress = 32'hC0000010;
    expCsCount++;
    @(posedge clock);
    #1;
    cpuRequest = 1'b0;
    @(posedge clock);
    #1;
    chk("rd2_busy_before_reset", 32'(cpuBusy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(cpuBusy), 32'd0);
    chk("abort_ready", 32'(cpuReady), 32'd0);
    chk("abort_rdata", cpuReadData, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    issue("ld_after_rst",  1'b0, 2'b10, 1'b0, 32'hC0000010, 32'h0,        1'b1, 18'h4,   4'b1111, 32'h0,        32'h80FF7F01);

    repeat (3) @(posedge clock);
    #1;
    chk("pending_responses", 32'(expQ.size()), 32'd0);
    chk("spm_access_count", 32'(csCount), 32'(expCsCount));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
